riscv_ctrl_fsm: RTL and testbench

RISCV_CTRL_FSM -- requirements
Module: riscv_ctrl_fsm

---
 rtl/riscv_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_fsm.sv
// rtl/riscv_ctrl_fsm.sv - multi-cycle RISC-V control FSM; define RISCV_CTRL_TRAP_EN to halt on illegal opcodes
module riscv_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insn,
  input  logic [6:0]  opcode,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap
);

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_insn;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_alu_en;
  logic        r_rf_we;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_writes;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_writes;
  logic        w_legal;

  // Classify the decoder's opcode into memory direction, writeback and legality
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_writes   = 1'b0;
    w_legal    = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        w_is_load = 1'b1;
        w_writes  = 1'b1;
      end
      OPC_STORE: w_is_store = 1'b1;
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: w_writes = 1'b1;
      OPC_BRANCH, OPC_SYSTEM: w_writes = 1'b0;
      default: w_legal = 1'b0;
    endcase
  end

`ifdef RISCV_CTRL_TRAP_EN
  logic r_trap;
  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

  // Sequencer: every strobe is registered and changes only on state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_insn     <= NOP_INSN;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_alu_en   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_writes   <= 1'b0;
`ifdef RISCV_CTRL_TRAP_EN
      r_trap     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          // an ack only counts once our own request is visible, so stale acks are dropped
          if (r_imem_req && imem_ack) begin
            r_insn     <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          // illegal opcodes decode as a plain NOP: no memory access, no writeback
          r_is_load  <= w_legal & w_is_load;
          r_is_store <= w_legal & w_is_store;
          r_writes   <= w_legal & w_writes;
`ifdef RISCV_CTRL_TRAP_EN
          if (!w_legal) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_state  <= S_EXECUTE;
            r_alu_en <= 1'b1;
          end
`else
          r_state  <= S_EXECUTE;
          r_alu_en <= 1'b1;
`endif
        end
        S_EXECUTE: begin
          r_alu_en <= 1'b0;
          if (r_is_load || r_is_store) begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= r_is_store;
          end else begin
            r_state <= S_WB;
            r_rf_we <= r_writes;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= r_writes;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          r_rf_we    <= 1'b0;
          r_pc       <= next_pc;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
`ifdef RISCV_CTRL_TRAP_EN
        S_TRAP: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_alu_en   <= 1'b0;
          r_rf_we    <= 1'b0;
        end
`endif
        default: begin
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_alu_en   <= 1'b0;
          r_rf_we    <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign insn      = r_insn;
  assign alu_en    = r_alu_en;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign rf_we     = r_rf_we;
  assign pc        = r_pc;
  assign state     = r_state;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// tb/tb_riscv_ctrl_fsm.sv - scoreboard bench for riscv_ctrl_fsm
`timescale 1ns/1ps
module tb_riscv_ctrl_fsm;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] insn;
  logic [6:0]  opcode;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        trap;

  riscv_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .insn(insn), .opcode(opcode), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .next_pc(next_pc), .pc(pc), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  // decoder model: opcode field of the latched instruction
  assign opcode = insn[6:0];

  typedef struct {
    logic        rf;
    logic        we;
    int          mem_cyc;
    int          cyc;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: accumulate per-instruction observations, compare after each writeback
  int   m_cyc = 0, m_mem = 0, m_alu = 0;
  logic m_we = 1'b0, m_rf = 1'b0, m_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_mem = 0; m_alu = 0; m_we = 1'b0; m_rf = 1'b0; m_pend = 1'b0;
    end else begin
      chk("strobe_mutex", {31'd0, ($countones({alu_en, dmem_req, rf_we}) <= 1)}, 32'd1);
      if (m_pend) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_unexpected_wb: got writeback expected none");
        end else begin
          m_e = sb_q.pop_front();
          chk("wb_rf_we", {31'd0, m_rf}, {31'd0, m_e.rf});
          chk("dmem_we", {31'd0, m_we}, {31'd0, m_e.we});
          chk("mem_cycles", m_mem, m_e.mem_cyc);
          chk("alu_cycles", m_alu, 1);
          chk("insn_cycles", m_cyc, m_e.cyc);
          chk("pc_after_wb", pc, m_e.npc);
          chk("state_after_wb", {29'd0, state}, 32'd0);
        end
        m_cyc = 0; m_mem = 0; m_alu = 0; m_we = 1'b0; m_rf = 1'b0; m_pend = 1'b0;
      end
      case (state)
        3'd0: if (imem_req) m_cyc++;
        3'd1: m_cyc++;
        3'd2: begin m_cyc++; if (alu_en) m_alu++; end
        3'd3: begin m_cyc++; if (dmem_req) m_mem++; if (dmem_we) m_we = 1'b1; end
        3'd4: begin m_cyc++; m_rf = rf_we; m_pend = 1'b1; end
        default: ;
      endcase
    end
  end

  task automatic wait_req();
    int t = 0;
    while (imem_req !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (imem_req !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL fetch_timeout: imem_req=%b expected 1", imem_req);
    end
  endtask

  task automatic do_fetch(input logic [31:0] w, input int fd, input logic [31:0] npc);
    wait_req();
    chk("imem_addr", imem_addr, cur_pc);
    next_pc = npc;
    repeat (fd) @(negedge clk);
    imem_rdata = w;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_mem(input int n);
    int t = 0;
    while (dmem_req !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (dmem_req !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL mem_timeout: dmem_req=%b expected 1", dmem_req);
    end
    repeat (n - 1) @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic run(input logic [31:0] w, input int fd, input int mn, input logic [31:0] npc,
                     input logic rf, input logic we, input int cyc);
    exp_t e;
    e.rf = rf; e.we = we; e.mem_cyc = mn; e.cyc = cyc; e.npc = npc;
    sb_q.push_back(e);
    do_fetch(w, fd, npc);
    if (mn > 0) do_mem(mn);
    cur_pc = npc;
  endtask

  task automatic chk_idle_reset();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_insn", insn, NOP);
    chk("rst_strobes", {27'd0, imem_req, dmem_req, dmem_we, alu_en, rf_we}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
  endtask

  initial begin
    int t;
    cur_pc = RST_PC;
    // reset with stale acks pending across release
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'h0000_2103;
    repeat (2) @(negedge clk);
    chk_idle_reset();
    #2 rst_n = 1'b1;
    chk("req_before_edge", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("req_first_edge", {31'd0, imem_req}, 32'd1);
    chk("stale_ack_insn", insn, NOP);
    chk("stale_ack_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;

    //   word            fd mn npc            rf we cyc
    run(32'h0010_0093, 0, 0, 32'h0000_0104, 1, 0, 4);   // ADDI
    run(32'h0000_2103, 0, 3, 32'h0000_0108, 1, 0, 7);   // LW, 3 MEM cycles
    run(32'h0020_2023, 2, 1, 32'h0000_010C, 0, 1, 7);   // SW, slow fetch
    run(32'h0000_0463, 1, 0, 32'h0000_0200, 0, 0, 5);   // BEQ
    run(32'h0000_12B7, 0, 0, 32'h0000_0204, 1, 0, 4);   // LUI

    // stray dmem_ack in FETCH, stray imem_ack in DECODE
    begin
      exp_t e;
      e.rf = 1'b1; e.we = 1'b0; e.mem_cyc = 0; e.cyc = 6; e.npc = 32'h0000_0208;
      sb_q.push_back(e);
      wait_req();
      next_pc = 32'h0000_0208;
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("stray_dack_state", {29'd0, state}, 32'd0);
      chk("stray_dack_insn", insn, 32'h0000_12B7);
      chk("stray_dack_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      imem_rdata = 32'h0020_0113; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'h1234_5678; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stray_iack_insn", insn, 32'h0020_0113);
      chk("stray_iack_state", {29'd0, state}, 32'd2);
      cur_pc = 32'h0000_0208;
    end

    // asynchronous reset while a load is in MEM
    do_fetch(32'h0000_2103, 0, 32'h0000_0300);
    t = 0;
    while (dmem_req !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("mid_mem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b1;
    #1;
    chk("async_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk_idle_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_after_release", {31'd0, imem_req}, 32'd1);
    chk("state_after_release", {29'd0, state}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    cur_pc = RST_PC;
    run(32'h0010_0093, 0, 0, 32'h0000_0104, 1, 0, 4);

`ifdef RISCV_CTRL_TRAP_EN
    do_fetch(32'hFFFF_FFFF, 0, 32'h0000_0400);
    @(negedge clk);
    repeat (20) begin
      chk("trap_state", {29'd0, state}, 32'd5);
      chk("trap_flag", {31'd0, trap}, 32'd1);
      chk("trap_pc", pc, cur_pc);
      chk("trap_strobes", {28'd0, imem_req, dmem_req, alu_en, rf_we}, 32'd0);
      @(negedge clk);
    end
`else
    run(32'hFFFF_FFFF, 0, 0, 32'h0000_0400, 0, 0, 4);   // illegal -> NOP
    run(32'h0010_0093, 0, 0, 32'h0000_0404, 1, 0, 4);   // fetch resumes
`endif

    t = 0;
    while (sb_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("sb_drained", sb_q.size(), 0);
`ifndef RISCV_CTRL_TRAP_EN
    chk("trap_tied", {31'd0, trap}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
